// File: rtl/press_if.sv
// Handshake bundle between the game controller/button conditioners and press_arbiter.
interface press_if #(
  parameter int N      = 2,
  parameter int DROP_W = 8
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic              start;
  logic              stop;
  logic [N-1:0]      press;
  logic [N-1:0]      grant;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output start, stop, press,
    input  grant, grant_id, busy, drop_cnt
  );

  modport slave (
    input  start, stop, press,
    output grant, grant_id, busy, drop_cnt
  );
endinterface

// File: rtl/press_arbiter.sv
// Round-robin arbiter for single-cycle button presses with post-grant lockout.
// Optional macro PRESS_QUEUE_EN holds presses seen during lockout for the next decision.
//
// state     | meaning
// S_IDLE    | disarmed, presses ignored and not counted
// S_ARMED   | waiting for a press; decides a winner on any request
// S_LOCKOUT | post-grant lockout, busy=1, presses dropped (or queued)
module press_arbiter #(
  parameter int N           = 2,
  parameter int LOCK_CYCLES = 4,
  parameter int DROP_W      = 8
) (
  input logic   Clock,
  input logic   Reset,
  press_if.slave bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int PW  = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_LOCKOUT} state_t;

  state_t            state_q, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [IDW-1:0]    ptr_q, ptr_n;
  logic [N-1:0]      grant_q, grant_n;
  logic [IDW-1:0]    id_q, id_n;
  logic [DROP_W-1:0] drop_q, drop_n;
  logic [PW-1:0]     drop_add;
  logic [DROP_W:0]   drop_sum;

  logic [N-1:0]      req;
  logic [N-1:0]      arm_drop;
  logic [N-1:0]      lock_drop;
  logic              win_found;
  logic [IDW-1:0]    win_idx;
  logic [N-1:0]      win_oh;

  function automatic logic [PW-1:0] popcnt(input logic [N-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + PW'(v[i]);
    return c;
  endfunction

`ifdef PRESS_QUEUE_EN
  logic [N-1:0] pend_q, pend_n;

  assign req       = pend_q | bus.press;
  // Already-pending requesters losing again are kept, not counted twice.
  assign arm_drop  = bus.press & ~pend_q & ~win_oh;
  assign lock_drop = bus.press & pend_q;

  always_comb begin
    pend_n = pend_q;
    if (bus.stop) begin
      pend_n = '0;
    end else if (state_q == S_LOCKOUT) begin
      pend_n = pend_q | bus.press;
    end else if (state_q == S_ARMED && win_found) begin
      pend_n = pend_q & ~win_oh;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) pend_q <= '0;
    else       pend_q <= pend_n;
  end
`else
  assign req       = bus.press;
  assign arm_drop  = req & ~win_oh;
  assign lock_drop = bus.press;
`endif

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req[(int'(ptr_q) + i) % N]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(ptr_q) + i) % N);
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = win_found;
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    ptr_n    = ptr_q;
    grant_n  = '0;
    id_n     = id_q;
    drop_add = '0;
    case (state_q)
      S_IDLE: begin
        if (!bus.stop && bus.start) state_n = S_ARMED;
      end
      S_ARMED: begin
        if (bus.stop) begin
          state_n = S_IDLE;
        end else if (win_found) begin
          state_n  = S_LOCKOUT;
          cnt_n    = CW'(LOCK_CYCLES - 1);
          grant_n  = win_oh;
          id_n     = win_idx;
          ptr_n    = (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);
          drop_add = popcnt(arm_drop);
        end
      end
      S_LOCKOUT: begin
        if (bus.stop) begin
          state_n = S_IDLE;
        end else begin
          drop_add = popcnt(lock_drop);
          if (cnt_q == '0) state_n = S_ARMED;
          else             cnt_n   = cnt_q - CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(drop_add);
  assign drop_n   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ptr_q   <= ptr_n;
      grant_q <= grant_n;
      id_q    <= id_n;
      drop_q  <= drop_n;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = id_q;
  assign bus.busy     = (state_q == S_LOCKOUT);
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_press_arbiter.sv
// Directed, table-driven bench for press_arbiter with N=2, LOCK_CYCLES=4, DROP_W=8.
module tb_press_arbiter;
  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  always #5 Clock = ~Clock;

  press_if #(.N(2), .DROP_W(8)) bus ();

  press_arbiter #(.N(2), .LOCK_CYCLES(4), .DROP_W(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic       start;
    logic       stop;
    logic [1:0] press;
    logic [1:0] grant;
    logic       gid;
    logic       busy;
    logic [7:0] drop;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    //            start stop press  grant gid busy drop
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b0, 2'b11, 2'b10, 1'b1, 1'b1, 8'd1};
    vecs[8]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 8'd1};
    vecs[9]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 8'd1};
    vecs[11] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 8'd1};
    vecs[12] = '{1'b0, 1'b0, 2'b11, 2'b01, 1'b0, 1'b1, 8'd2};
    vecs[13] = '{1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 8'd3};
    vecs[14] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 8'd3};
    vecs[15] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 8'd3};
    vecs[16] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'd3};
    vecs[17] = '{1'b0, 1'b0, 2'b11, 2'b10, 1'b1, 1'b1, 8'd4};
    vecs[18] = '{1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 8'd4};
    vecs[19] = '{1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 8'd4};
    vecs[20] = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 8'd4};
    vecs[21] = '{1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 8'd4};
    vecs[22] = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 8'd4};
    vecs[23] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 8'd4};

    Reset     = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.press = 2'b00;
    repeat (2) step();
    chk("reset grant", 32'(bus.grant), 32'd0);
    chk("reset grant_id", 32'(bus.grant_id), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset drop_cnt", 32'(bus.drop_cnt), 32'd0);
    Reset = 1'b0;

    for (int k = 0; k < 24; k++) begin
      bus.start = vecs[k].start;
      bus.stop  = vecs[k].stop;
      bus.press = vecs[k].press;
      step();
      chk($sformatf("v%0d grant", k), 32'(bus.grant), 32'(vecs[k].grant));
      chk($sformatf("v%0d grant_id", k), 32'(bus.grant_id), 32'(vecs[k].gid));
      chk($sformatf("v%0d busy", k), 32'(bus.busy), 32'(vecs[k].busy));
      chk($sformatf("v%0d drop_cnt", k), 32'(bus.drop_cnt), 32'(vecs[k].drop));
    end

    // Reset in the cycle right after a grant clears everything on the next edge.
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.press = 2'b00;
    Reset     = 1'b1;
    step();
    chk("rst_after_grant grant", 32'(bus.grant), 32'd0);
    chk("rst_after_grant grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_after_grant busy", 32'(bus.busy), 32'd0);
    chk("rst_after_grant drop_cnt", 32'(bus.drop_cnt), 32'd0);
    Reset     = 1'b0;
    bus.press = 2'b01;
    step();
    chk("no_start grant", 32'(bus.grant), 32'd0);
    chk("no_start busy", 32'(bus.busy), 32'd0);
    chk("no_start drop_cnt", 32'(bus.drop_cnt), 32'd0);

    // Continuous colliding presses drive drop_cnt into saturation.
    bus.press = 2'b00;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.press = 2'b11;
    step();
    chk("sat first grant", 32'(bus.grant), 32'b01);
    chk("sat first drop_cnt", 32'(bus.drop_cnt), 32'd1);
    for (int k = 0; k < 300; k++) begin
      step();
      chk("sat grant onehot", 32'($countones(bus.grant) <= 1), 32'd1);
    end
    chk("sat drop_cnt", 32'(bus.drop_cnt), 32'd255);
    repeat (6) step();
    chk("sat drop_cnt hold", 32'(bus.drop_cnt), 32'd255);
    bus.press = 2'b00;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
